arbiter_3req: RTL and testbench

ARBITER_3REQ -- requirements
Module: arbiter_3req

---
 rtl/arbiter_3req.sv | 171 +++++++++++++++++
 tb/tb_arbiter_3req.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_3req.sv
// Three-requester arbiter: fixed-priority or round-robin selection, with a
// MAX_HOLD timeout that forces re-arbitration while other requesters wait.
module arbiter_3req #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] req,
  input  logic       mode,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_gnt, w_gnt_nxt;
  logic [1:0] r_gnt_id, w_id_nxt;
  logic       r_gnt_valid, w_valid_nxt;
  logic       r_preempt, w_preempt_nxt;
  logic [7:0] r_hold_cnt, w_hold_nxt;
  logic [1:0] r_last_id, w_last_nxt;

  logic [2:0] w_pick_full;
  logic [2:0] w_pick_masked;
  logic       w_cur_req;
  logic       w_new;
  logic       w_go_idle;
  logic [1:0] w_new_id;

  // Returns {found, index}; round-robin scans last+1, last+2, last (mod 3).
  function automatic logic [2:0] pick(input logic [2:0] r, input logic rr,
                                      input logic [1:0] last);
    logic [1:0] o0;
    logic [1:0] o1;
    logic [1:0] o2;
    o0 = 2'd0;
    o1 = 2'd1;
    o2 = 2'd2;
    pick = 3'b000;
    if (rr) begin
      case (last)
        2'd0:    begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
        2'd1:    begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
        default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
      endcase
      if (r[o0])      pick = {1'b1, o0};
      else if (r[o1]) pick = {1'b1, o1};
      else if (r[o2]) pick = {1'b1, o2};
      else            pick = 3'b000;
    end else begin
      if (r[2])       pick = 3'b110;
      else if (r[1])  pick = 3'b101;
      else if (r[0])  pick = 3'b100;
      else            pick = 3'b000;
    end
  endfunction

  function automatic logic [2:0] onehot(input logic [1:0] id);
    case (id)
      2'd0:    onehot = 3'b001;
      2'd1:    onehot = 3'b010;
      2'd2:    onehot = 3'b100;
      default: onehot = 3'b000;
    endcase
  endfunction

  assign w_pick_full   = pick(req, mode, r_last_id);
  assign w_pick_masked = pick(req & ~r_gnt, mode, r_last_id);
  assign w_cur_req     = |(req & r_gnt);

  // Arbitration decision and next values of every registered field.
  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_id_nxt      = r_gnt_id;
    w_valid_nxt   = r_gnt_valid;
    w_preempt_nxt = 1'b0;
    w_hold_nxt    = r_hold_cnt;
    w_last_nxt    = r_last_id;
    w_new         = 1'b0;
    w_go_idle     = 1'b0;
    w_new_id      = 2'd0;

    case (r_state)
      ST_IDLE: begin
        if (w_pick_full[2]) begin
          w_new    = 1'b1;
          w_new_id = w_pick_full[1:0];
        end else begin
          w_go_idle = 1'b1;
        end
      end
      ST_BUSY: begin
        if (!w_cur_req) begin
          if (w_pick_full[2]) begin
            w_new    = 1'b1;
            w_new_id = w_pick_full[1:0];
          end else begin
            w_go_idle = 1'b1;
          end
        end else if (r_hold_cnt >= HOLD_LAST) begin
          // Timeout: a waiting requester takes over, else the owner is re-granted.
          w_new = 1'b1;
          if (w_pick_masked[2]) begin
            w_new_id      = w_pick_masked[1:0];
            w_preempt_nxt = 1'b1;
          end else begin
            w_new_id = r_gnt_id;
          end
        end else begin
          w_hold_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_go_idle = 1'b1;
      end
    endcase

    if (w_go_idle) begin
      w_state_nxt = ST_IDLE;
      w_gnt_nxt   = 3'b000;
      w_id_nxt    = 2'd0;
      w_valid_nxt = 1'b0;
      w_hold_nxt  = 8'd0;
    end else if (w_new) begin
      w_state_nxt = ST_BUSY;
      w_gnt_nxt   = onehot(w_new_id);
      w_id_nxt    = w_new_id;
      w_valid_nxt = 1'b1;
      w_hold_nxt  = 8'd0;
      w_last_nxt  = w_new_id;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= 3'b000;
      r_gnt_id    <= 2'd0;
      r_gnt_valid <= 1'b0;
      r_preempt   <= 1'b0;
      r_hold_cnt  <= 8'd0;
      r_last_id   <= 2'd2;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_id    <= w_id_nxt;
      r_gnt_valid <= w_valid_nxt;
      r_preempt   <= w_preempt_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_last_id   <= w_last_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign preempt   = r_preempt;

endmodule

// File: tb/tb_arbiter_3req.sv
// Directed bench for arbiter_3req; outputs are packed as {gnt, gnt_id, gnt_valid, preempt}.
module tb_arbiter_3req;

  logic       clk;
  logic       reset_n;
  logic [2:0] req;
  logic       mode;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       preempt;
  logic [6:0] obs;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [6:0] O_IDLE = 7'b000_00_0_0;
  localparam logic [6:0] O_G0   = 7'b001_00_1_0;
  localparam logic [6:0] O_G1   = 7'b010_01_1_0;
  localparam logic [6:0] O_G2   = 7'b100_10_1_0;
  localparam logic [6:0] O_G0P  = 7'b001_00_1_1;
  localparam logic [6:0] O_G2P  = 7'b100_10_1_1;

  arbiter_3req #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .preempt   (preempt)
  );

  assign obs = {gnt, gnt_id, gnt_valid, preempt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = 3'b111; mode = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_IDLE) begin
        n_bad++;
        $display("FAIL reset cyc%0d: got %b want %b", i, obs, O_IDLE);
      end
    end
    reset_n = 1'b1; req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL reset_release: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_fixed_priority();
    mode = 1'b0; req = 3'b011;
    tick();
    n_cmp++;
    if (obs !== O_G1) begin
      n_bad++;
      $display("FAIL fixed_first: got %b want %b", obs, O_G1);
    end
    req = 3'b111;
    for (int i = 0; i < 7; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_G1) begin
        n_bad++;
        $display("FAIL fixed_hold cyc%0d: got %b want %b", i, obs, O_G1);
      end
    end
    tick();
    n_cmp++;
    if (obs !== O_G2P) begin
      n_bad++;
      $display("FAIL fixed_timeout: got %b want %b", obs, O_G2P);
    end
    tick();
    n_cmp++;
    if (obs !== O_G2) begin
      n_bad++;
      $display("FAIL fixed_preempt_pulse: got %b want %b", obs, O_G2);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL fixed_to_idle: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_timeout();
    mode = 1'b0; req = 3'b101;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_G2) begin
        n_bad++;
        $display("FAIL timeout_hold cyc%0d: got %b want %b", i, obs, O_G2);
      end
    end
    tick();
    n_cmp++;
    if (obs !== O_G0P) begin
      n_bad++;
      $display("FAIL timeout_switch: got %b want %b", obs, O_G0P);
    end
    req = 3'b100;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_G2) begin
        n_bad++;
        $display("FAIL lone_hold cyc%0d: got %b want %b", i, obs, O_G2);
      end
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL timeout_to_idle: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] seq_req [4];
    logic [6:0] seq_exp [4];
    seq_req[0] = 3'b111; seq_exp[0] = O_G0;
    seq_req[1] = 3'b110; seq_exp[1] = O_G1;
    seq_req[2] = 3'b101; seq_exp[2] = O_G2;
    seq_req[3] = 3'b011; seq_exp[3] = O_G0;
    reset_n = 1'b0; req = 3'b000;
    tick();
    reset_n = 1'b1; mode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req = seq_req[i];
      tick();
      n_cmp++;
      if (obs !== seq_exp[i]) begin
        n_bad++;
        $display("FAIL rr_order step%0d: got %b want %b", i, obs, seq_exp[i]);
      end
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL rr_to_idle: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_release_idle();
    mode = 1'b0; req = 3'b010;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_G1) begin
        n_bad++;
        $display("FAIL release_hold cyc%0d: got %b want %b", i, obs, O_G1);
      end
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL release_idle: got %b want %b", obs, O_IDLE);
    end
  endtask

  task automatic test_reset_mid_and_mode();
    mode = 1'b0; req = 3'b010;
    tick();
    n_cmp++;
    if (obs !== O_G1) begin
      n_bad++;
      $display("FAIL mid_grant: got %b want %b", obs, O_G1);
    end
    reset_n = 1'b0;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL mid_reset_drop: got %b want %b", obs, O_IDLE);
    end
    reset_n = 1'b1;
    tick();
    n_cmp++;
    if (obs !== O_G1) begin
      n_bad++;
      $display("FAIL after_reset_grant: got %b want %b", obs, O_G1);
    end
    mode = 1'b1; req = 3'b111;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if (obs !== O_G1) begin
        n_bad++;
        $display("FAIL mode_toggle_hold cyc%0d: got %b want %b", i, obs, O_G1);
      end
    end
    req = 3'b101;
    tick();
    n_cmp++;
    if (obs !== O_G2) begin
      n_bad++;
      $display("FAIL mode_release_rearb: got %b want %b", obs, O_G2);
    end
    req = 3'b000;
    tick();
    n_cmp++;
    if (obs !== O_IDLE) begin
      n_bad++;
      $display("FAIL mode_to_idle: got %b want %b", obs, O_IDLE);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 3'b000;
    mode    = 1'b0;
    test_reset();
    test_fixed_priority();
    test_timeout();
    test_round_robin();
    test_release_idle();
    test_reset_mid_and_mode();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
